// File: rtl/med_blocos_pkg.sv
// Shared types and sizing helpers for the block-mean downscaler sequencer.
package med_blocos_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam int DEF_SRC_W = 160;
    localparam int DEF_SRC_H = 120;
    localparam int DEF_BLK   = 4;
    localparam int DEF_PIX_W = 8;

    function automatic int calc_saw(input int w, input int h);
        return $clog2(w * h);
    endfunction

    function automatic int calc_daw(input int w, input int h, input int blk);
        return $clog2((w / blk) * (h / blk));
    endfunction

    function automatic int calc_shift(input int blk);
        return 2 * $clog2(blk);
    endfunction

    function automatic int calc_acc_w(input int pix_w, input int blk);
        return pix_w + 2 * $clog2(blk);
    endfunction

endpackage

// File: rtl/med_blocos_acc.sv
// Block accumulator: sums one block of pixels; mean_o is the sum shifted down by log2(BLK^2).
module med_blocos_acc
    import med_blocos_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int BLK   = DEF_BLK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [PIX_W-1:0] din_i,
    output logic [PIX_W-1:0] mean_o
);

    localparam int ACC_W = calc_acc_w(PIX_W, BLK);
    localparam int SHIFT = calc_shift(BLK);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(din_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Width is exactly PIX_W + SHIFT, so the top slice is the truncated mean.
    assign mean_o = acc_q[ACC_W-1:SHIFT];

endmodule

// File: rtl/med_blocos_ctrl.sv
// Block-mean downscaler sequencer: walks the source frame block by block, one read per cycle,
// and writes each block mean to the destination RAM in raster order.
module med_blocos_ctrl
    import med_blocos_pkg::*;
#(
    parameter  int SRC_W = DEF_SRC_W,
    parameter  int SRC_H = DEF_SRC_H,
    parameter  int BLK   = DEF_BLK,
    parameter  int PIX_W = DEF_PIX_W,
    localparam int SAW   = calc_saw(SRC_W, SRC_H),
    localparam int DAW   = calc_daw(SRC_W, SRC_H, BLK)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             src_rd_en,
    output logic [SAW-1:0]   src_addr,
    input  logic [PIX_W-1:0] src_data,
    output logic             dst_we,
    output logic [DAW-1:0]   dst_addr,
    output logic [PIX_W-1:0] dst_data
);

    localparam int NBX = SRC_W / BLK;
    localparam int NBY = SRC_H / BLK;
    localparam int BXW = (NBX > 1) ? $clog2(NBX) : 1;
    localparam int BYW = (NBY > 1) ? $clog2(NBY) : 1;
    localparam int RCW = $clog2(BLK);

    state_t           state_q, state_d;
    logic [BXW-1:0]   bx_q, bx_d;
    logic [BYW-1:0]   by_q, by_d;
    logic [RCW-1:0]   r_q, r_d;
    logic [RCW-1:0]   c_q, c_d;
    logic             rd_vld_q;
    logic             done_q, done_d;
    logic [PIX_W-1:0] mean;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            bx_q     <= '0;
            by_q     <= '0;
            r_q      <= '0;
            c_q      <= '0;
            rd_vld_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            r_q      <= r_d;
            c_q      <= c_d;
            rd_vld_q <= (state_q == ST_RUN);
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        r_d     = r_q;
        c_d     = c_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    bx_d    = '0;
                    by_d    = '0;
                    r_d     = '0;
                    c_d     = '0;
                end
            end
            ST_RUN: begin
                if (c_q == RCW'(BLK - 1)) begin
                    c_d = '0;
                    if (r_q == RCW'(BLK - 1)) begin
                        r_d     = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        r_d = r_q + 1'b1;
                    end
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_RUN;
                if (bx_q == BXW'(NBX - 1)) begin
                    bx_d = '0;
                    if (by_q == BYW'(NBY - 1)) begin
                        // Last block: counters return to zero so the next frame starts clean.
                        by_d    = '0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        by_d = by_q + 1'b1;
                    end
                end else begin
                    bx_d = bx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Data read in a RUN cycle lands one cycle later, so the final pixel arrives during DRAIN.
    med_blocos_acc #(
        .PIX_W (PIX_W),
        .BLK   (BLK)
    ) u_acc (
        .clk    (clk),
        .reset  (reset),
        .clr_i  ((state_q == ST_IDLE) || (state_q == ST_WRITE)),
        .en_i   (rd_vld_q),
        .din_i  (src_data),
        .mean_o (mean)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign src_rd_en = (state_q == ST_RUN);
    assign dst_we    = (state_q == ST_WRITE);

    assign src_addr = (state_q == ST_RUN)
                    ? SAW'((32'(by_q) * BLK + 32'(r_q)) * SRC_W + 32'(bx_q) * BLK + 32'(c_q))
                    : '0;
    assign dst_addr = (state_q == ST_WRITE) ? DAW'(32'(by_q) * NBX + 32'(bx_q)) : '0;
    assign dst_data = (state_q == ST_WRITE) ? mean : '0;

endmodule
